// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 word type, round constants and initial hash words
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam word_t K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_full_adder_cell.sv
// rtl/sha256_full_adder_cell.sv - 1-bit full adder plus and/or taps, replicated by wider adders
module sha256_full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out,
    output logic and_out,
    output logic or_out
);

    logic half_sum;

    assign half_sum  = a ^ b;
    assign sum       = half_sum ^ carry_in;
    assign carry_out = (a & b) | (carry_in & half_sum);
    assign and_out   = a & b;
    assign or_out    = a | b;

endmodule

// File: rtl/sha256_const_unit.sv
// rtl/sha256_const_unit.sv - SHA-256 round-constant lookup, initial hash bus and adder cell
module sha256_const_unit
    import sha256_pkg::*;
#(
    parameter bit K_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [5:0]   k_addr,
    output logic [31:0]  k_value,
    output logic [255:0] init_hash,
    input  logic         a,
    input  logic         b,
    input  logic         carry_in,
    output logic         sum,
    output logic         carry_out,
    output logic         and_out,
    output logic         or_out
);

    assign init_hash = {H_INIT[0], H_INIT[1], H_INIT[2], H_INIT[3],
                        H_INIT[4], H_INIT[5], H_INIT[6], H_INIT[7]};

    // rst_n is active high here: 1 clears the registered constant.
    generate
        if (K_REG) begin : g_k_reg
            word_t k_q;
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    k_q <= '0;
                end else begin
                    k_q <= K_TABLE[k_addr];
                end
            end
            assign k_value = k_q;
        end else begin : g_k_comb
            assign k_value = K_TABLE[k_addr];
        end
    endgenerate

    sha256_full_adder_cell u_fa (
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out),
        .and_out   (and_out),
        .or_out    (or_out)
    );

endmodule

// File: tb/tb_sha256_const_unit.sv
// tb/tb_sha256_const_unit.sv - self-checking bench for sha256_const_unit (registered and combinational builds)
module tb_sha256_const_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   k_addr;
    logic [5:0]   k_addr_c;
    logic         a, b, carry_in;
    logic [31:0]  k_value, k_value_c;
    logic [255:0] init_hash, init_hash_c;
    logic         sum, carry_out, and_out, or_out;
    logic         sum_c, carry_out_c, and_out_c, or_out_c;

    int checks = 0;
    int errors = 0;

    logic [31:0]  k_ref [64];
    logic [31:0]  h_ref [8];
    logic [255:0] h_bus_ref;

    always #5 clk = ~clk;

    sha256_const_unit #(.K_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .k_addr(k_addr), .k_value(k_value),
        .init_hash(init_hash), .a(a), .b(b), .carry_in(carry_in),
        .sum(sum), .carry_out(carry_out), .and_out(and_out), .or_out(or_out)
    );

    sha256_const_unit #(.K_REG(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .k_addr(k_addr_c), .k_value(k_value_c),
        .init_hash(init_hash_c), .a(a), .b(b), .carry_in(carry_in),
        .sum(sum_c), .carry_out(carry_out_c), .and_out(and_out_c), .or_out(or_out_c)
    );

    // K = first 32 fractional bits of cube roots of the first 64 primes,
    // H = first 32 fractional bits of square roots of the first 8 primes.
    task automatic build_model();
        int  n = 2;
        int  cnt = 0;
        real r;
        real f;
        while (cnt < 64) begin
            bit is_prime = 1'b1;
            for (int d = 2; d * d <= n; d++)
                if (n % d == 0) is_prime = 1'b0;
            if (is_prime) begin
                r = real'(n) ** (1.0 / 3.0);
                f = r - $floor(r);
                k_ref[cnt] = 32'(longint'($floor(f * 4294967296.0)));
                if (cnt < 8) begin
                    r = $sqrt(real'(n));
                    f = r - $floor(r);
                    h_ref[cnt] = 32'(longint'($floor(f * 4294967296.0)));
                end
                cnt++;
            end
            n++;
        end
        h_bus_ref = '0;
        for (int i = 0; i < 8; i++)
            h_bus_ref = {h_bus_ref[223:0], h_ref[i]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_init(input string tag);
        checks++;
        if (init_hash !== h_bus_ref) begin
            errors++;
            $display("FAIL init_hash_%s: got %h expected %h", tag, init_hash, h_bus_ref);
        end
        checks++;
        if (init_hash_c !== h_bus_ref) begin
            errors++;
            $display("FAIL init_hash_c_%s: got %h expected %h", tag, init_hash_c, h_bus_ref);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        k_addr = 6'd5;
        #1;
        check_init("t0");
        tick();
        tick();
        checks++;
        if (k_value !== 32'h0) begin
            errors++;
            $display("FAIL reset_value: got %h expected %h", k_value, 32'h0);
        end
        check_init("in_reset");
        rst_n = 1'b0;
        k_addr = 6'd0;
        tick();
        checks++;
        if (k_value !== 32'h428a2f98) begin
            errors++;
            $display("FAIL first_after_reset: got %h expected %h", k_value, 32'h428a2f98);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i <= 64; i++) begin
            k_addr = 6'(i);
            tick();
            checks++;
            if (k_value !== k_ref[i % 64]) begin
                errors++;
                $display("FAIL sweep_k%0d: got %h expected %h", i, k_value, k_ref[i % 64]);
            end
            if (i == 1 || i == 63) begin
                checks++;
                if (k_value !== ((i == 1) ? 32'h71374491 : 32'hc67178f2)) begin
                    errors++;
                    $display("FAIL sweep_fixed_k%0d: got %h", i, k_value);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [31:0] exp;
        for (int i = 20; i <= 40; i++) begin
            k_addr = 6'(i);
            rst_n = (i >= 30 && i < 32);
            tick();
            exp = rst_n ? 32'h0 : k_ref[i];
            checks++;
            if (k_value !== exp) begin
                errors++;
                $display("FAIL mid_reset_addr%0d: got %h expected %h", i, k_value, exp);
            end
            if (i == 32) begin
                checks++;
                if (k_value !== 32'h27b70a85) begin
                    errors++;
                    $display("FAIL mid_reset_k32: got %h expected 27b70a85", k_value);
                end
            end
        end
        rst_n = 1'b0;
    endtask

    task automatic test_random_lookup();
        logic [31:0] exp;
        for (int i = 0; i < 200; i++) begin
            k_addr = 6'($urandom_range(0, 63));
            rst_n = ($urandom_range(0, 15) == 0);
            tick();
            exp = rst_n ? 32'h0 : k_ref[k_addr];
            checks++;
            if (k_value !== exp) begin
                errors++;
                $display("FAIL rand_lookup_%0d: addr %0d rst %b got %h expected %h",
                         i, k_addr, rst_n, k_value, exp);
            end
        end
        rst_n = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check_init("after_100");
    endtask

    task automatic test_adder();
        int total;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] v;
            v = (i < 8) ? 3'(i) : 3'($urandom_range(0, 7));
            {carry_in, b, a} = v;
            #1;
            total = int'(a) + int'(b) + int'(carry_in);
            checks++;
            if ({sum, carry_out, and_out, or_out} !==
                {total[0], total >= 2, a == 1'b1 && b == 1'b1, a == 1'b1 || b == 1'b1}) begin
                errors++;
                $display("FAIL adder_%0d: in %b got s%b c%b and%b or%b", i, v,
                         sum, carry_out, and_out, or_out);
            end
            checks++;
            if ({sum_c, carry_out_c} !== {total[0], total >= 2}) begin
                errors++;
                $display("FAIL adder_c_%0d: in %b got s%b c%b", i, v, sum_c, carry_out_c);
            end
        end
    endtask

    task automatic test_comb_lookup();
        k_addr_c = 6'd10;
        #1;
        checks++;
        if (k_value_c !== 32'h243185be) begin
            errors++;
            $display("FAIL comb_k10: got %h expected 243185be", k_value_c);
        end
        k_addr_c = 6'd11;
        #1;
        checks++;
        if (k_value_c !== 32'h550c7dc3) begin
            errors++;
            $display("FAIL comb_k11: got %h expected 550c7dc3", k_value_c);
        end
        for (int i = 0; i < 64; i++) begin
            k_addr_c = 6'($urandom_range(0, 63));
            #1;
            checks++;
            if (k_value_c !== k_ref[k_addr_c]) begin
                errors++;
                $display("FAIL comb_rand_%0d: addr %0d got %h expected %h",
                         i, k_addr_c, k_value_c, k_ref[k_addr_c]);
            end
        end
    endtask

    initial begin
        k_addr_c = 6'd0;
        a = 1'b0;
        b = 1'b0;
        carry_in = 1'b0;
        build_model();
        test_reset();
        test_sweep();
        test_reset_mid_sweep();
        test_random_lookup();
        test_adder();
        test_comb_lookup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
